// File: rtl/matmul_pkg.sv
// Shared widths, default matrix base addresses and FSM encoding for matmul_controller.
// Saturating accumulation is enabled by defining MATMUL_SAT_EN (see mac_unit).
package matmul_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] A_BASE_DEF = 17'd0;
    localparam logic [ADDR_W-1:0] B_BASE_DEF = 17'd64;
    localparam logic [ADDR_W-1:0] C_BASE_DEF = 17'd128;

    // Encodings kept identical to the legacy localparam values.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_C = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_controller_mac.sv
// mac_unit: latches the A operand, multiplies by the B operand and accumulates.
// With MATMUL_SAT_EN defined the accumulator saturates at all-ones instead of wrapping.
module mac_unit
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load_a,
    input  logic              i_acc_en,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_sat
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_next;

`ifdef MATMUL_SAT_EN
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]     w_sum;

    // Once saturated, any nonzero product carries out again, so the
    // accumulator stays pinned at all-ones for the rest of the element.
    always_comb begin
        w_prod = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, i_rdata};
        w_sum  = {1'b0, r_acc} + {1'b0, w_prod[DATA_W-1:0]};
        o_sat  = i_acc_en && ((|w_prod[2*DATA_W-1:DATA_W]) || w_sum[DATA_W]);
        w_next = o_sat ? '1 : w_sum[DATA_W-1:0];
    end
`else
    assign w_next = r_acc + r_a * i_rdata;
    assign o_sat  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_acc <= '0;
        end else begin
            if (i_load_a)
                r_a <= i_rdata;
            if (i_clear)
                r_acc <= '0;
            else if (i_acc_en)
                r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/matmul_controller.sv
// Sequential DIMxDIM matrix multiply C = A*B over a single-port word memory.
// Overflow behaviour follows MATMUL_SAT_EN (saturate + sticky ovf) or wraps when undefined.
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int                DIM    = 3,
    parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
    parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
    parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam int             IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_k;
    logic             r_ovf;

    logic              w_accept;
    logic              w_sat;
    logic [DATA_W-1:0] w_acc;

    function automatic logic [ADDR_W-1:0] mat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  row,
                                                   input logic [IDX_W-1:0]  col);
        return base + ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
    endfunction

    assign w_accept = (r_state == S_IDLE) && start;

    mac_unit u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept || (r_state == S_WR_C)),
        .i_load_a (r_state == S_RD_A),
        .i_acc_en (r_state == S_RD_B),
        .i_rdata  (rdata),
        .o_acc    (w_acc),
        .o_sat    (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept)
                r_ovf <= 1'b0;
            else if (w_sat)
                r_ovf <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_RD_A;
                    end
                end
                S_RD_A: r_state <= S_RD_B;
                S_RD_B: begin
                    if (r_k == LAST) begin
                        r_k     <= '0;
                        r_state <= S_WR_C;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_state <= S_RD_A;
                    end
                end
                S_WR_C: begin
                    // Row-major walk: j is the fast index, the last element ends the run.
                    if (r_j == LAST) begin
                        r_j <= '0;
                        if (r_i == LAST) begin
                            r_i     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= S_RD_A;
                        end
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= S_RD_A;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        address  = '0;
        wdata    = '0;
        case (r_state)
            S_RD_A: begin
                busy    = 1'b1;
                memread = 1'b1;
                address = mat_addr(A_BASE, r_i, r_k);
            end
            S_RD_B: begin
                busy    = 1'b1;
                memread = 1'b1;
                address = mat_addr(B_BASE, r_k, r_j);
            end
            S_WR_C: begin
                busy     = 1'b1;
                memwrite = 1'b1;
                address  = mat_addr(C_BASE, r_i, r_j);
                wdata    = w_acc;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign ovf = r_ovf;

endmodule

// File: tb/tb_matmul_controller.sv
// Scoreboard bench for matmul_controller: DIM=3 and DIM=2 instances sharing one reference model.
// Expected C writes and done timing are computed from A/B in the bench memory model.
module tb_matmul_controller;

    typedef struct {
        int          u;
        logic [16:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int   u;
        int   cyc;
        logic ov;
    } dn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic        ovf   [2];
    logic        mr    [2];
    logic        mw    [2];
    logic [16:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic [31:0] mem   [2][256];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wr_cnt [2];
    logic last_ovf [2];
    logic [31:0] c0_seen [2];

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd[0] = mem[0][addr[0][7:0]];
    assign rd[1] = mem[1][addr[1][7:0]];

    matmul_controller #(.DIM(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .ovf(ovf[0]), .memread(mr[0]), .memwrite(mw[0]), .address(addr[0]),
        .wdata(wd[0]), .rdata(rd[0])
    );

    matmul_controller #(.DIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .ovf(ovf[1]), .memread(mr[1]), .memwrite(mw[1]), .address(addr[1]),
        .wdata(wd[1]), .rdata(rd[1])
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dim_of(input int u);
        return (u == 0) ? 3 : 2;
    endfunction

    function automatic logic [31:0] rnd(input int mode);
        case (mode)
            0:       return 32'($urandom_range(0, 255));
            1:       return $urandom;
            default: return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic clear_mem(input int u);
        for (int x = 0; x < 256; x++) mem[u][x] = '0;
    endtask

    task automatic fill_rand(input int u, input int mode);
        int n;
        n = dim_of(u) * dim_of(u);
        for (int x = 0; x < n; x++) begin
            mem[u][x]      = rnd(mode);
            mem[u][64 + x] = rnd(mode);
        end
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapped mod 2^32 or saturated.
    task automatic push_ref(input int u, input int done_cyc);
        logic [63:0] acc;
        logic [63:0] p;
        logic        ov;
        int          dim;
        dim = dim_of(u);
        ov  = 1'b0;
        for (int i = 0; i < dim; i++) begin
            for (int j = 0; j < dim; j++) begin
                acc = '0;
                for (int k = 0; k < dim; k++) begin
                    p = 64'(mem[u][i*dim + k]) * 64'(mem[u][64 + k*dim + j]);
`ifdef MATMUL_SAT_EN
                    if (p > 64'hFFFF_FFFF || acc + p > 64'hFFFF_FFFF) begin
                        acc = 64'hFFFF_FFFF;
                        ov  = 1'b1;
                    end else begin
                        acc = acc + p;
                    end
`else
                    acc = (acc + p) % 64'h1_0000_0000;
`endif
                end
                exp_wr.push_back('{u, 17'(128 + i*dim + j), acc[31:0]});
            end
        end
        exp_dn.push_back('{u, done_cyc, ov});
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_run(input int u);
        int s;
        int n;
        n = dim_of(u) * dim_of(u) * (2 * dim_of(u) + 1);
        @(posedge clk);
        #1;
        s = cyc;
        start[u] = 1'b1;
        push_ref(u, s + n + 1);
        wait_cyc(s + 1);
        start[u] = 1'b0;
        wait_cyc(s + n + 4);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        int  dim;
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                dim = dim_of(u);
                if (mr[u] || mw[u]) begin
                    check("rw_exclusive", longint'(mr[u] & mw[u]), 0);
                    check("busy_during_access", longint'(busy[u]), 1);
                end
                if (mr[u])
                    check("read_range", longint'((addr[u] < 17'(dim*dim)) ||
                          (addr[u] >= 17'd64 && addr[u] < 17'(64 + dim*dim))), 1);
                if (mw[u]) begin
                    check("write_range", longint'(addr[u] >= 17'd128 && addr[u] < 17'(128 + dim*dim)), 1);
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", longint'(mw[u]), 0);
                    end else begin
                        w = exp_wr.pop_front();
                        check("write_unit", w.u, u);
                        check("write_addr", longint'(addr[u]), longint'(w.addr));
                        check("write_data", longint'(wd[u]), longint'(w.data));
                        wr_cnt[u]++;
                        if (addr[u] == 17'd128) c0_seen[u] = wd[u];
                    end
                end
                if (done[u]) begin
                    check("done_busy_low", longint'(busy[u]), 0);
                    if (exp_dn.size() == 0) begin
                        check("unexpected_done", longint'(done[u]), 0);
                    end else begin
                        d = exp_dn.pop_front();
                        check("done_unit", d.u, u);
                        check("done_cycle", cyc, d.cyc);
                        check("done_ovf", longint'(ovf[u]), longint'(d.ov));
                        check("write_count", wr_cnt[u], dim * dim);
                        last_ovf[u] = d.ov;
                    end
                    wr_cnt[u] = 0;
                end
                if (!busy[u] && !done[u]) begin
                    check("idle_outputs", longint'({mr[u], mw[u], addr[u], wd[u]}), 0);
                    check("idle_ovf_hold", longint'(ovf[u]), longint'(last_ovf[u]));
                end
            end
        end
    end

    initial begin
        int s;
        int n3;
        logic [31:0] exp_c0;
        logic        exp_ov;
        n3 = 63;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; wr_cnt[u] = 0; last_ovf[u] = 1'b0; c0_seen[u] = '0;
            clear_mem(u);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++)
            check("reset_state", longint'({busy[u], done[u], ovf[u], mr[u], mw[u], addr[u], wd[u]}), 0);
        rst_n = 1'b1;

        // Directed: A = 1..9, B = checker pattern
        for (int x = 0; x < 9; x++) mem[0][x] = 32'(x + 1);
        for (int x = 0; x < 9; x++) mem[0][64 + x] = (x % 2 == 0) ? 32'd1 : 32'd0;
        do_run(0);

        // Directed: 0x8000_0000 * 2 overflows the 32-bit product
        clear_mem(0);
        mem[0][0]  = 32'h8000_0000;
        mem[0][64] = 32'd2;
        do_run(0);
`ifdef MATMUL_SAT_EN
        exp_c0 = 32'hFFFF_FFFF;
        exp_ov = 1'b1;
`else
        exp_c0 = 32'h0;
        exp_ov = 1'b0;
`endif
        check("ovf_case_c0", longint'(c0_seen[0]), longint'(exp_c0));
        check("ovf_case_flag", longint'(ovf[0]), longint'(exp_ov));

        // Random runs
        for (int r = 0; r < 5; r++) begin
            fill_rand(0, r % 3);
            do_run(0);
        end

        // Start held high across two back-to-back runs
        fill_rand(0, 0);
        @(posedge clk);
        #1;
        s = cyc;
        start[0] = 1'b1;
        push_ref(0, s + n3 + 1);
        push_ref(0, s + 2*n3 + 3);
        wait_cyc(s + n3 + 2);
        check("held_idle_gap", longint'({busy[0], done[0]}), 0);
        wait_cyc(s + 2*n3 + 3);
        start[0] = 1'b0;
        wait_cyc(s + 2*n3 + 20);

        // Reset in cycle 20 of a run, then rerun on the same matrices
        fill_rand(0, 2);
        @(posedge clk);
        #1;
        s = cyc;
        start[0] = 1'b1;
        push_ref(0, s + n3 + 1);
        wait_cyc(s + 1);
        start[0] = 1'b0;
        wait_cyc(s + 20);
        rst_n = 1'b0;
        exp_wr.delete();
        exp_dn.delete();
        for (int u = 0; u < 2; u++) begin
            wr_cnt[u] = 0; last_ovf[u] = 1'b0;
        end
        #1;
        check("midrun_reset_outputs",
              longint'({busy[0], done[0], ovf[0], mr[0], mw[0], addr[0], wd[0]}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        do_run(0);

        // DIM=2: A = {1,2;3,4}, B = identity
        mem[1][0] = 32'd1; mem[1][1] = 32'd2; mem[1][2] = 32'd3; mem[1][3] = 32'd4;
        mem[1][64] = 32'd1; mem[1][65] = 32'd0; mem[1][66] = 32'd0; mem[1][67] = 32'd1;
        do_run(1);
        for (int r = 0; r < 3; r++) begin
            fill_rand(1, r);
            do_run(1);
        end

        repeat (10) @(posedge clk);
        #1;
        check("pending_writes", exp_wr.size(), 0);
        check("pending_done", exp_dn.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
